spi_xfer_ctrl: RTL and testbench

Transfer sequencer between the host-side FIFOs and the SPI master. It accepts a transfer descriptor (byte count, receive enable, CS hold) and then runs the whole transfer. For each byte it pops the TX FIFO, launches the SPI master, waits for completion, and pushes the received byte into the RX FIFO. It owns chip-select timing and raises a one-cycle done pulse for the IRQ logic.

---
 rtl/spi_xfer_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// Per-transfer sequencer: CS setup, per-byte TX pop / SPI launch / RX push, CS hold, done pulse.
// Stalls on an empty TX FIFO or a full RX FIFO; abort is honoured at the next byte boundary.
module spi_xfer_ctrl #(
  parameter logic [3:0] CS_SETUP = 4'd2,
  parameter logic [3:0] CS_HOLD  = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_len,
  input  logic       cmd_rx_en,
  input  logic       cmd_hold_cs,
  input  logic       abort,
  input  logic       tx_nempty,
  input  logic [7:0] tx_data,
  output logic       tx_pop,
  input  logic       rx_full,
  output logic       rx_push,
  output logic [7:0] rx_data,
  output logic       spi_go,
  input  logic       spi_state,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_dout,
  output logic       cs_assert,
  output logic       busy,
  output logic       done,
  output logic [8:0] bytes_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FETCH = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    STORE = 3'd5,
    HOLD  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       init_q, init_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;
  logic       rx_en_q, rx_en_d;
  logic       hold_cs_q, hold_cs_d;
  logic       aborted_q, aborted_d;
  logic       cs_q, cs_d;
  logic       tx_pop_q, tx_pop_d;
  logic       spi_go_q, spi_go_d;
  logic [7:0] spi_din_q, spi_din_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [8:0] bytes_done_q, bytes_done_d;
  logic       done_q, done_d;
  logic       rx_push_c;

  logic setup_last;
  logic hold_last;
  logic last_byte;

  // A zero-length CS period still spends one cycle in its state.
  assign setup_last = ({1'b0, cnt_q} + 5'd1) >= {1'b0, CS_SETUP};
  assign hold_last  = ({1'b0, cnt_q} + 5'd1) >= {1'b0, CS_HOLD};
  assign last_byte  = bytes_done_q == ({1'b0, len_q} + 9'd1);

  always_comb begin
    state_d      = state_q;
    init_d       = 1'b1;
    cnt_d        = cnt_q;
    len_d        = len_q;
    rx_en_d      = rx_en_q;
    hold_cs_d    = hold_cs_q;
    aborted_d    = aborted_q;
    cs_d         = cs_q;
    tx_pop_d     = 1'b0;
    spi_go_d     = spi_go_q;
    spi_din_d    = spi_din_q;
    rx_data_d    = rx_data_q;
    bytes_done_d = bytes_done_q;
    done_d       = 1'b0;
    rx_push_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d        = cmd_len;
          rx_en_d      = cmd_rx_en;
          hold_cs_d    = cmd_hold_cs;
          aborted_d    = 1'b0;
          bytes_done_d = 9'd0;
          cs_d         = 1'b1;
          cnt_d        = 4'd0;
          state_d      = SETUP;
        end
      end

      SETUP: begin
        if (abort) aborted_d = 1'b1;
        if (setup_last) begin
          cnt_d   = 4'd0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      FETCH: begin
        if (abort || aborted_q) begin
          aborted_d = 1'b1;
          cnt_d     = 4'd0;
          state_d   = HOLD;
        end else if (tx_nempty) begin
          tx_pop_d  = 1'b1;
          spi_din_d = tx_data;
          state_d   = START;
        end
      end

      START: begin
        if (abort) aborted_d = 1'b1;
        // Only trust spi_state once our request has been visible for a cycle.
        if (spi_go_q && spi_state) begin
          spi_go_d = 1'b0;
          state_d  = WAIT;
        end else begin
          spi_go_d = 1'b1;
        end
      end

      WAIT: begin
        if (abort) aborted_d = 1'b1;
        if (!spi_state) begin
          rx_data_d    = spi_dout;
          bytes_done_d = bytes_done_q + 9'd1;
          state_d      = STORE;
        end
      end

      STORE: begin
        if (abort) aborted_d = 1'b1;
        if (!rx_en_q || !rx_full) begin
          rx_push_c = rx_en_q;
          if (last_byte || abort || aborted_q) begin
            cnt_d   = 4'd0;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HOLD: begin
        if (hold_last) begin
          if (!hold_cs_q || aborted_q) cs_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      init_q       <= 1'b0;
      cnt_q        <= 4'd0;
      len_q        <= 8'd0;
      rx_en_q      <= 1'b0;
      hold_cs_q    <= 1'b0;
      aborted_q    <= 1'b0;
      cs_q         <= 1'b0;
      tx_pop_q     <= 1'b0;
      spi_go_q     <= 1'b0;
      spi_din_q    <= 8'd0;
      rx_data_q    <= 8'd0;
      bytes_done_q <= 9'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      rx_en_q      <= rx_en_d;
      hold_cs_q    <= hold_cs_d;
      aborted_q    <= aborted_d;
      cs_q         <= cs_d;
      tx_pop_q     <= tx_pop_d;
      spi_go_q     <= spi_go_d;
      spi_din_q    <= spi_din_d;
      rx_data_q    <= rx_data_d;
      bytes_done_q <= bytes_done_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = init_q && (state_q == IDLE);
  assign busy       = state_q != IDLE;
  assign tx_pop     = tx_pop_q;
  assign rx_push    = rx_push_c;
  assign rx_data    = rx_data_q;
  assign spi_go     = spi_go_q;
  assign spi_din    = spi_din_q;
  assign cs_assert  = cs_q;
  assign done       = done_q;
  assign bytes_done = bytes_done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: FIFO and loopback SPI models, scoreboarded RX/TX bytes.
module tb_spi_xfer_ctrl;
  localparam logic [3:0] CS_SETUP = 4'd2;
  localparam logic [3:0] CS_HOLD  = 4'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = 8'd0;
  logic       cmd_rx_en = 1'b0;
  logic       cmd_hold_cs = 1'b0;
  logic       abort = 1'b0;
  logic       tx_nempty = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_pop;
  logic       rx_full = 1'b0;
  logic       rx_push;
  logic [7:0] rx_data;
  logic       spi_go;
  logic       spi_state;
  logic [7:0] spi_din;
  logic [7:0] spi_dout;
  logic       cs_assert;
  logic       busy;
  logic       done;
  logic [8:0] bytes_done;

  spi_xfer_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_rx_en(cmd_rx_en), .cmd_hold_cs(cmd_hold_cs), .abort(abort),
    .tx_nempty(tx_nempty), .tx_data(tx_data), .tx_pop(tx_pop),
    .rx_full(rx_full), .rx_push(rx_push), .rx_data(rx_data),
    .spi_go(spi_go), .spi_state(spi_state), .spi_din(spi_din), .spi_dout(spi_dout),
    .cs_assert(cs_assert), .busy(busy), .done(done), .bytes_done(bytes_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_fifo[$];
  logic [7:0] exp_rx[$];
  logic [7:0] got_rx[$];
  logic [7:0] exp_din[$];
  logic [7:0] got_din[$];
  int pops = 0, pushes = 0, dones = 0, cs_falls = 0, overlap = 0;
  int cs_rise_cyc = 0, go_rise_cyc = 0;
  logic go_prev = 1'b0, cs_prev = 1'b0;

  // Loopback SPI master: 16 busy cycles, returns the byte it was given.
  logic [4:0] scnt;
  logic [7:0] sbuf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_state <= 1'b0;
      scnt      <= 5'd0;
      sbuf      <= 8'd0;
      spi_dout  <= 8'd0;
    end else if (!spi_state) begin
      if (spi_go) begin
        spi_state <= 1'b1;
        scnt      <= 5'd16;
        sbuf      <= spi_din;
      end
    end else begin
      if (scnt == 5'd1) begin
        spi_state <= 1'b0;
        spi_dout  <= sbuf;
      end
      scnt <= scnt - 5'd1;
    end
  end

  // Monitor and FWFT TX FIFO model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (tx_pop) begin
      pops++;
      if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
    end
    if (rx_push) begin
      pushes++;
      got_rx.push_back(rx_data);
    end
    if (tx_pop && rx_push) overlap++;
    if (spi_go && !go_prev) begin
      got_din.push_back(spi_din);
      go_rise_cyc = cyc;
    end
    if (cs_assert && !cs_prev) cs_rise_cyc = cyc;
    if (!cs_assert && cs_prev) cs_falls++;
    if (done) dones++;
    go_prev   = spi_go;
    cs_prev   = cs_assert;
    tx_nempty = tx_fifo.size() > 0;
    tx_data   = (tx_fifo.size() > 0) ? tx_fifo[0] : 8'h00;
  end

  task automatic start_cmd(input logic [7:0] len, input logic rxe, input logic hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_len     = len;
    cmd_rx_en   = rxe;
    cmd_hold_cs = hold;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, cs_assert, spi_go, tx_pop, rx_push, done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready/busy/cs/go/pop/push/done=%b required 0000000",
               {cmd_ready, busy, cs_assert, spi_go, tx_pop, rx_push, done});
    end
    checks++;
    if (bytes_done !== 9'd0 || spi_din !== 8'd0 || rx_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: bytes_done=%0d spi_din=%h rx_data=%h required 0", bytes_done, spi_din, rx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: cmd_ready=%b required 1 after first clock", cmd_ready);
    end
  endtask

  task automatic test_single();
    int p0, q0, d0;
    logic [7:0] e, g;
    p0 = pops; q0 = pushes; d0 = dones;
    tx_fifo.push_back(8'hA5); exp_rx.push_back(8'hA5); exp_din.push_back(8'hA5);
    start_cmd(8'd0, 1'b1, 1'b0);
    wait_done(200);
    checks++;
    if (go_rise_cyc - cs_rise_cyc !== int'(CS_SETUP) + 2) begin
      failures++;
      $display("FAIL single_cs_to_go: %0d cycles, required %0d", go_rise_cyc - cs_rise_cyc, int'(CS_SETUP) + 2);
    end
    checks++;
    if (pops - p0 !== 1 || pushes - q0 !== 1 || dones - d0 !== 1) begin
      failures++;
      $display("FAIL single_counts: pops=%0d pushes=%0d dones=%0d required 1 1 1", pops - p0, pushes - q0, dones - d0);
    end
    checks++;
    if (bytes_done !== 9'd1 || cs_assert !== 1'b0) begin
      failures++;
      $display("FAIL single_end: bytes_done=%0d cs=%b required 1 0", bytes_done, cs_assert);
    end
    while (exp_din.size() > 0) begin
      e = exp_din.pop_front();
      g = (got_din.size() > 0) ? got_din.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL single_spi_din: got %h required %h", g, e);
      end
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL single_rx_data: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_burst();
    int p0, q0, bad;
    logic [7:0] e, g;
    p0 = pops; q0 = pushes; bad = 0;
    for (int i = 0; i < 256; i++) begin
      tx_fifo.push_back(8'(i)); exp_rx.push_back(8'(i)); exp_din.push_back(8'(i));
    end
    start_cmd(8'd255, 1'b1, 1'b0);
    wait_done(20000);
    checks++;
    if (pops - p0 !== 256 || pushes - q0 !== 256) begin
      failures++;
      $display("FAIL burst_counts: pops=%0d pushes=%0d required 256 256", pops - p0, pushes - q0);
    end
    checks++;
    if (bytes_done !== 9'd256) begin
      failures++;
      $display("FAIL burst_bytes_done: %0d required 256", bytes_done);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        if (bad++ < 8) $display("FAIL burst_rx_order: got %h required %h", g, e);
      end
    end
    while (exp_din.size() > 0) begin
      e = exp_din.pop_front();
      g = (got_din.size() > 0) ? got_din.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        if (bad++ < 8) $display("FAIL burst_spi_din: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_tx_stall();
    int q0, n, bad;
    logic [7:0] e, g;
    q0 = pushes; n = 0; bad = 0;
    tx_fifo.push_back(8'h11); tx_fifo.push_back(8'h22);
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33); exp_rx.push_back(8'h44);
    start_cmd(8'd3, 1'b1, 1'b0);
    while (pushes - q0 < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spi_go || !cs_assert) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL tx_stall_hold: %0d stall cycles with spi_go=1 or cs=0, required 0", bad);
    end
    tx_fifo.push_back(8'h33); tx_fifo.push_back(8'h44);
    wait_done(500);
    checks++;
    if (bytes_done !== 9'd4) begin
      failures++;
      $display("FAIL tx_stall_bytes_done: %0d required 4", bytes_done);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL tx_stall_rx: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_rx_stall();
    int q0, n, t;
    logic [7:0] e, g;
    q0 = pushes; n = 0;
    tx_fifo.push_back(8'h5A); tx_fifo.push_back(8'hC3);
    exp_rx.push_back(8'h5A); exp_rx.push_back(8'hC3);
    rx_full = 1'b1;
    start_cmd(8'd1, 1'b1, 1'b0);
    while (bytes_done !== 9'd1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (pushes !== q0) begin
      failures++;
      $display("FAIL rx_stall_early: %0d pushes while full, required 0", pushes - q0);
    end
    rx_full = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_push !== 1'b1 || cyc - t !== 7) begin
      failures++;
      $display("FAIL rx_stall_delay: rx_push=%b at delay %0d, required 1 at 7", rx_push, cyc - t);
    end
    wait_done(500);
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL rx_stall_data: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_abort();
    int p0, q0, d0, n;
    logic [7:0] e, g;
    p0 = pops; q0 = pushes; d0 = dones; n = 0;
    for (int i = 0; i < 8; i++) begin
      tx_fifo.push_back(8'(8'h80 + i));
      if (i < 3) exp_rx.push_back(8'(8'h80 + i));
    end
    start_cmd(8'd7, 1'b1, 1'b1);
    while (!(pops - p0 == 3 && spi_state && !spi_go) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    wait_done(500);
    abort = 1'b0;
    checks++;
    if (pops - p0 !== 3 || pushes - q0 !== 3) begin
      failures++;
      $display("FAIL abort_counts: pops=%0d pushes=%0d required 3 3", pops - p0, pushes - q0);
    end
    checks++;
    if (bytes_done !== 9'd3 || cs_assert !== 1'b0 || dones - d0 !== 1) begin
      failures++;
      $display("FAIL abort_end: bytes_done=%0d cs=%b dones=%0d required 3 0 1", bytes_done, cs_assert, dones - d0);
    end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL abort_rx: got %h required %h", g, e);
      end
    end
    tx_fifo.delete();
    got_din.delete();
  endtask

  task automatic test_chain();
    int q0, d0, f0;
    q0 = pushes; d0 = dones; f0 = cs_falls;
    tx_fifo.push_back(8'h01); tx_fifo.push_back(8'h02); tx_fifo.push_back(8'h03);
    start_cmd(8'd1, 1'b1, 1'b1);
    wait_done(500);
    checks++;
    if (cs_assert !== 1'b1 || cs_falls !== f0) begin
      failures++;
      $display("FAIL chain_held: cs=%b falls=%0d required 1 0", cs_assert, cs_falls - f0);
    end
    start_cmd(8'd0, 1'b0, 1'b0);
    wait_done(500);
    checks++;
    if (cs_assert !== 1'b0 || cs_falls - f0 !== 1 || dones - d0 !== 2) begin
      failures++;
      $display("FAIL chain_end: cs=%b falls=%0d dones=%0d required 0 1 2", cs_assert, cs_falls - f0, dones - d0);
    end
    checks++;
    if (pushes - q0 !== 2 || bytes_done !== 9'd1) begin
      failures++;
      $display("FAIL chain_pushes: pushes=%0d bytes_done=%0d required 2 1", pushes - q0, bytes_done);
    end
    got_rx.delete();
    got_din.delete();
  endtask

  task automatic test_reset_mid();
    int p0, q0, n;
    p0 = pops; n = 0;
    tx_fifo.push_back(8'h3C);
    start_cmd(8'd0, 1'b1, 1'b0);
    while (!(pops - p0 == 1 && spi_state && !spi_go) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (cs_assert !== 1'b0 || spi_go !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: cs=%b go=%b busy=%b required 0 0 0", cs_assert, spi_go, busy);
    end
    p0 = pops; q0 = pushes;
    repeat (3) @(negedge clk);
    tx_fifo.delete();
    got_rx.delete();
    got_din.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: cmd_ready=%b required 1", cmd_ready);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pops !== p0 || pushes !== q0 || got_din.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_strobes: pops=%0d pushes=%0d go=%0d after reset, required 0",
               pops - p0, pushes - q0, got_din.size());
    end
  endtask

  task automatic test_exclusive_strobes();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL pop_push_overlap: %0d cycles with both strobes, required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_tx_stall();
    test_rx_stall();
    test_abort();
    test_chain();
    test_reset_mid();
    test_exclusive_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
